// File: rtl/lut_layer_scheduler_if.sv
// Stream, config and status bundle for the LogicNets layer scheduler.
// The master drives vectors and config; the slave is the scheduler.
interface lut_layer_scheduler_if #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int FANIN       = 3,
  parameter int IN_BITS     = 2,
  parameter int OUT_BITS    = 2
);
  localparam int LA_W   = FANIN * IN_BITS;
  localparam int NW     = $clog2(NUM_NEURONS);
  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int CFG_AW = NW + LA_W;
  localparam int CFG_DW = (OUT_BITS > IDX_W) ? OUT_BITS : IDX_W;

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_INPUTS*IN_BITS-1:0]   in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
  logic                            cfg_we;
  logic                            cfg_sel;
  logic [CFG_AW-1:0]               cfg_addr;
  logic [CFG_DW-1:0]               cfg_data;
  logic                            cfg_err;
  logic                            busy;

  modport master (
    output in_valid, in_data, out_ready,
    output cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data,
    input  cfg_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    input  cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data,
    output cfg_err, busy
  );
endinterface

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LogicNets layer: one shared truth-table memory read
// once per neuron, results assembled into the layer output vector.
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int FANIN       = 3,
  parameter int IN_BITS     = 2,
  parameter int OUT_BITS    = 2
) (
  input logic clk,
  input logic rst,
  lut_layer_scheduler_if.slave io
);
  localparam int LA_W    = FANIN * IN_BITS;
  localparam int NW      = $clog2(NUM_NEURONS);
  localparam int IDX_W   = $clog2(NUM_INPUTS);
  localparam int CFG_AW  = NW + LA_W;
  localparam int CFG_DW  = (OUT_BITS > IDX_W) ? OUT_BITS : IDX_W;
  localparam int TT_N    = NUM_NEURONS << LA_W;
  localparam int CONN_N  = NUM_NEURONS * FANIN;
  localparam int CONN_AW = $clog2(CONN_N);
  localparam int IN_W    = NUM_INPUTS * IN_BITS;
  localparam int OUT_W   = NUM_NEURONS * OUT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NW-1:0]     k_q, k_d;
  logic [IN_W-1:0]   in_reg_q, in_reg_d;
  logic [OUT_BITS-1:0] rd_q, rd_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;
  logic              busy_q, busy_d;

  logic [OUT_BITS-1:0] tt_mem [TT_N];
  logic [IDX_W-1:0]    conn_mem [CONN_N];

  logic [LA_W-1:0]   lut_addr;
  logic [IDX_W-1:0]  sel_idx;
  logic              idle;
  logic              in_fire;
  logic              out_fire;
  logic              conn_bad;
  logic              cfg_ok;
  logic              tt_we;
  logic              conn_we;
  logic              wr_en;
  logic [NW-1:0]     wr_slot;

  assign idle     = (state_q == IDLE);
  assign in_fire  = io.in_valid & io.in_ready;
  assign out_fire = out_valid_q & io.out_ready;

  // Connectivity writes must name a real neuron input and a real feature.
  assign conn_bad = (32'(io.cfg_addr) >= CONN_N)
                  | (32'(io.cfg_data) >= NUM_INPUTS);
  assign cfg_ok   = io.cfg_we & idle & rst
                  & ~(io.cfg_sel & conn_bad);
  assign tt_we    = cfg_ok & ~io.cfg_sel;
  assign conn_we  = cfg_ok & io.cfg_sel;

  always_comb begin
    cfg_err_d = io.cfg_we
              & (~idle | (io.cfg_sel & conn_bad));
  end

  always_comb begin
    lut_addr = '0;
    sel_idx  = '0;
    for (int j = 0; j < FANIN; j++) begin
      sel_idx = conn_mem[CONN_AW'(int'(k_q) * FANIN + j)];
      lut_addr[j*IN_BITS +: IN_BITS] =
        in_reg_q[int'(sel_idx)*IN_BITS +: IN_BITS];
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    in_reg_d = in_reg_q;
    rd_d     = rd_q;
    wr_en    = 1'b0;
    wr_slot  = '0;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          in_reg_d = io.in_data;
          k_d      = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        rd_d    = tt_mem[{k_q, lut_addr}];
        wr_en   = (k_q != '0);
        wr_slot = k_q - NW'(1);
        k_d     = k_q + NW'(1);
        if (k_q == NW'(NUM_NEURONS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wr_en   = 1'b1;
        wr_slot = NW'(NUM_NEURONS - 1);
        state_d = DONE;
      end
      DONE: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    for (int s = 0; s < NUM_NEURONS; s++) begin
      if (wr_en && (wr_slot == NW'(s))) begin
        out_data_d[s*OUT_BITS +: OUT_BITS] = rd_q;
      end
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == EVAL) | (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      in_reg_q    <= '0;
      rd_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      in_reg_q    <= in_reg_d;
      rd_q        <= rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  // Config memories survive reset so a mid-run reset needs no reload.
  always_ff @(posedge clk) begin
    if (tt_we) begin
      tt_mem[io.cfg_addr] <= io.cfg_data[OUT_BITS-1:0];
    end
    if (conn_we) begin
      conn_mem[CONN_AW'(io.cfg_addr)] <= io.cfg_data[IDX_W-1:0];
    end
  end

  assign io.in_ready  = idle & rst;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.cfg_err   = cfg_err_q;
  assign io.busy      = busy_q;
endmodule
